// File: rtl/fpga_cpu_pkg.sv
// ---------------------------------------------------------------------------
// fpga_cpu_pkg
// Shared constants and types for the fpga_cpu RAM arbiter slice.
//   ARB_AW / ARB_DW / ARB_MAX_WAIT : default RAM geometry and loader patience
//   PORT_CPU / PORT_DBG            : requester indices into grant vectors
//   arb_state_e                    : arbiter FSM states
// ---------------------------------------------------------------------------
package fpga_cpu_pkg;

  localparam int ARB_AW       = 4;
  localparam int ARB_DW       = 8;
  localparam int ARB_MAX_WAIT = 3;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fpga_cpu_ram_arbiter_age_counter.sv
// ---------------------------------------------------------------------------
// arb_age_counter
// Saturating up-counter with synchronous clear. Tracks how many consecutive
// cycles the loader has been refused.
//   clk, reset (async, active-high)
//   i_inc   : count up one (ignored once saturated)
//   i_clr   : return to zero (wins over i_inc)
//   o_count : current count
//   o_sat   : count has reached MAX_WAIT
// ---------------------------------------------------------------------------
module arb_age_counter #(
  parameter  int MAX_WAIT = 3,
  localparam int CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [CW-1:0] o_count,
  output logic          o_sat
);

  logic [CW-1:0] r_count;

  assign o_sat   = (r_count == CW'(MAX_WAIT));
  assign o_count = r_count;

  // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/fpga_cpu_ram_arbiter.sv
// ---------------------------------------------------------------------------
// fpga_cpu_ram_arbiter
// Shares the single-port synchronous program/data RAM between the CPU bus and
// the debug/program loader. CPU has fixed priority; the loader is forced a
// grant after losing MAX_WAIT cycles in a row, and may lock the RAM for a
// burst with dbg_lock (CPU is stalled while locked).
//   clk, reset (async, active-high)
//   cpu_req/we/addr/wdata -> cpu_gnt (comb), cpu_rvalid (reg), cpu_rdata
//   dbg_req/we/addr/wdata -> dbg_gnt (comb), dbg_rvalid (reg), dbg_rdata
//   dbg_lock              : loader keeps the RAM while high after its grant
//   cpu_stall             : registered, high while the loader holds the lock
//   mem_en/we/addr/wdata  : RAM request; mem_rdata arrives one cycle later
// ---------------------------------------------------------------------------
module fpga_cpu_ram_arbiter
  import fpga_cpu_pkg::*;
#(
  parameter int AW       = ARB_AW,
  parameter int DW       = ARB_DW,
  parameter int MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_lock,
  output logic          cpu_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [1:0]    w_win;
  logic [1:0]    w_gnt;
  logic          w_age_sat;
  logic [CW-1:0] w_age;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_cpu_rvalid;
  logic          r_dbg_rvalid;

  // Loader patience: counts refused cycles, cleared on grant or when idle.
  arb_age_counter #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (dbg_req && !dbg_gnt),
    .i_clr   (dbg_gnt || !dbg_req),
    .o_count (w_age),
    .o_sat   (w_age_sat)
  );

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    w_win       = 2'b00;
    w_state_nxt = r_state;
    case (r_state)
      ARB: begin
        w_win[PORT_DBG] = dbg_req && (w_age_sat || !cpu_req);
        w_win[PORT_CPU] = cpu_req && !w_win[PORT_DBG];
        if (w_win[PORT_DBG] && dbg_lock) w_state_nxt = LOCKED;
      end
      LOCKED: begin
        // The cycle dbg_lock drops still belongs to the loader.
        w_win[PORT_DBG] = dbg_req;
        if (!dbg_lock) w_state_nxt = ARB;
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // Grants are masked by reset so no RAM access escapes once reset asserts.
  assign w_gnt   = reset ? 2'b00 : w_win;
  assign cpu_gnt = w_gnt[PORT_CPU];
  assign dbg_gnt = w_gnt[PORT_DBG];

  assign mem_en    = |w_gnt;
  assign mem_we    = (cpu_gnt && cpu_we) || (dbg_gnt && dbg_we);
  assign mem_addr  = cpu_gnt ? cpu_addr  : (dbg_gnt ? dbg_addr  : r_mem_addr);
  assign mem_wdata = cpu_gnt ? cpu_wdata : (dbg_gnt ? dbg_wdata : r_mem_wdata);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ARB;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cpu_rvalid <= cpu_gnt && !cpu_we;
      r_dbg_rvalid <= dbg_gnt && !dbg_we;
      if (mem_en) begin
        r_mem_addr  <= mem_addr;
        r_mem_wdata <= mem_wdata;
      end
    end
  end

  // Stall follows the state flop, so it drops immediately on async reset.
  assign cpu_stall  = (r_state == LOCKED);
  assign cpu_rvalid = r_cpu_rvalid;
  assign dbg_rvalid = r_dbg_rvalid;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_fpga_cpu_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpga_cpu_ram_arbiter
// Directed bench for fpga_cpu_ram_arbiter with a write-first synchronous
// 16x8 RAM model attached to the mem_* port. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_fpga_cpu_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [3:0] cpu_addr, dbg_addr;
  logic [7:0] cpu_wdata, dbg_wdata;
  logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, cpu_stall;
  logic [7:0] cpu_rdata, dbg_rdata;
  logic       mem_en, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] ram [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpga_cpu_ram_arbiter #(.AW(4), .DW(8), .MAX_WAIT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .dbg_lock   (dbg_lock),
    .cpu_stall  (cpu_stall),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Write-first synchronous RAM.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 8'h00;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 4'h0; dbg_wdata = 8'h00;
    dbg_lock = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en, mem_we, cpu_stall} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt/rv/en/we/stall=%b expected 0000000",
               {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en, mem_we, cpu_stall});
    end
    checks++;
    if (mem_addr !== 4'h0 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h expected 0/00", mem_addr, mem_wdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_gnt: cpu_gnt=%b dbg_gnt=%b expected 1/0", cpu_gnt, dbg_gnt);
    end
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'h3) begin
      errors++;
      $display("FAIL cpu_read_mem: en=%b we=%b addr=%h expected 1/0/3", mem_en, mem_we, mem_addr);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA5 || dbg_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_data: rvalid=%b rdata=%h dbg_rvalid=%b expected 1/a5/0",
               cpu_rvalid, cpu_rdata, dbg_rvalid);
    end
    checks++;
    if (mem_en !== 1'b0 || mem_addr !== 4'h3) begin
      errors++;
      $display("FAIL idle_hold: en=%b addr=%h expected 0/3", mem_en, mem_addr);
    end
  endtask

  task automatic test_contention();
    logic exp_c, prev_c;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'h1;
    prev_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_c = (i % 4) != 3;   // C,C,C,D repeating
      #1;
      checks++;
      if (cpu_gnt !== exp_c || dbg_gnt !== !exp_c) begin
        errors++;
        $display("FAIL contention_gnt[%0d]: cpu_gnt=%b dbg_gnt=%b expected %b/%b",
                 i, cpu_gnt, dbg_gnt, exp_c, !exp_c);
      end
      if (i > 0) begin
        checks++;
        if (cpu_rvalid !== prev_c || dbg_rvalid !== !prev_c) begin
          errors++;
          $display("FAIL contention_rvalid[%0d]: cpu_rvalid=%b dbg_rvalid=%b expected %b/%b",
                   i, cpu_rvalid, dbg_rvalid, prev_c, !prev_c);
        end
      end
      prev_c = exp_c;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_locked_burst();
    int n_dbg, n_cpu;
    n_dbg = 0; n_cpu = 0;
    @(negedge clk);
    dbg_req = 1'b1; dbg_lock = 1'b1; dbg_we = 1'b1; dbg_addr = 4'h0; dbg_wdata = 8'h10;
    #1;
    checks++;
    if (dbg_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL burst_first: dbg_gnt=%b cpu_stall=%b expected 1/0", dbg_gnt, cpu_stall);
    end
    n_dbg += int'(dbg_gnt); n_cpu += int'(cpu_gnt);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h8;
      dbg_addr = 4'(i); dbg_wdata = 8'h10 + 8'(i);
      dbg_lock = (i != 7);
      #1;
      n_dbg += int'(dbg_gnt); n_cpu += int'(cpu_gnt);
      checks++;
      if (cpu_stall !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'(i) || mem_wdata !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL burst_beat[%0d]: stall=%b we=%b addr=%h wdata=%h expected 1/1/%h/%h",
                 i, cpu_stall, mem_we, mem_addr, mem_wdata, 4'(i), 8'h10 + 8'(i));
      end
    end
    checks++;
    if (n_dbg != 8 || n_cpu != 0) begin
      errors++;
      $display("FAIL burst_counts: dbg_gnt=%0d cpu_gnt=%0d expected 8/0", n_dbg, n_cpu);
    end
    @(negedge clk);
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
    cpu_addr = 4'h5;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL unlock_cpu: cpu_gnt=%b cpu_stall=%b expected 1/0", cpu_gnt, cpu_stall);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h15) begin
      errors++;
      $display("FAIL burst_readback: rvalid=%b rdata=%h expected 1/15", cpu_rvalid, cpu_rdata);
    end
    checks++;
    if (ram[0] !== 8'h10 || ram[7] !== 8'h17) begin
      errors++;
      $display("FAIL burst_ram: ram0=%h ram7=%h expected 10/17", ram[0], ram[7]);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'hF; cpu_wdata = 8'h3C;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 8'h3C) begin
      errors++;
      $display("FAIL write_issue: gnt=%b we=%b wdata=%h expected 1/1/3c", cpu_gnt, mem_we, mem_wdata);
    end
    @(negedge clk);
    cpu_we = 1'b0; cpu_wdata = 8'h00;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rvalid: gnt=%b rvalid=%b expected 1/0", cpu_gnt, cpu_rvalid);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL raw_readback: rvalid=%b rdata=%h expected 1/3c", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_lock_without_req();
    @(negedge clk);
    dbg_lock = 1'b1; cpu_req = 1'b1; cpu_addr = 4'h0;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      errors++;
      $display("FAIL lock_noreq_gnt: cpu_gnt=%b dbg_gnt=%b expected 1/0", cpu_gnt, dbg_gnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || cpu_gnt !== 1'b1 || cpu_rdata !== 8'h10) begin
      errors++;
      $display("FAIL lock_noreq_state: stall=%b gnt=%b rdata=%h expected 0/1/10",
               cpu_stall, cpu_gnt, cpu_rdata);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_locked();
    @(negedge clk);
    dbg_req = 1'b1; dbg_lock = 1'b1; dbg_we = 1'b0; dbg_addr = 4'h2;
    #1;
    checks++;
    if (dbg_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstlock_grant: dbg_gnt=%b expected 1", dbg_gnt);
    end
    @(negedge clk);
    dbg_addr = 4'h3;
    #1;
    checks++;
    if (cpu_stall !== 1'b1 || dbg_gnt !== 1'b1 || dbg_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstlock_locked: stall=%b gnt=%b rvalid=%b expected 1/1/1",
               cpu_stall, dbg_gnt, dbg_rvalid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || dbg_gnt !== 1'b0 || mem_en !== 1'b0 || dbg_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstlock_immediate: stall=%b gnt=%b en=%b rvalid=%b expected 0/0/0/0",
               cpu_stall, dbg_gnt, mem_en, dbg_rvalid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dbg_rvalid !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL rstlock_edge: rvalid=%b stall=%b expected 0/0", dbg_rvalid, cpu_stall);
    end
    @(negedge clk);
    idle();
    reset = 1'b0;
  endtask

  task automatic test_reset_traffic();
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 4'h3; dbg_req = 1'b1; dbg_addr = 4'h1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en, cpu_stall} !== 6'b0) begin
      errors++;
      $display("FAIL traffic_reset: gnt/rv/en/stall=%b expected 000000",
               {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en, cpu_stall});
    end
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 4'hF;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_arb: cpu_gnt=%b stall=%b expected 1/0", cpu_gnt, cpu_stall);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[3]    = 8'hA5;
    mem_rdata = 8'h00;
    reset     = 1'b1;
    idle();
    test_reset();
    test_cpu_read();
    test_contention();
    test_locked_burst();
    test_write_read();
    test_lock_without_req();
    test_reset_locked();
    test_reset_traffic();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
